// File: rtl/fb_speed_pkg.sv
// Shared constants and helpers for the motor feedback speed meter.
// Holds the default timing for a 125 MHz clk and the width helper used for internal counters.
package fb_speed_pkg;

    localparam int CLK_HZ          = 125000000;
    localparam int DEF_WIN_CYC     = CLK_HZ / 10;
    localparam int DEF_FILT_CYC    = 8;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold values 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fb_edge_filter.sv
// One feedback channel: multi-flop synchroniser, stability glitch filter and a
// registered one-cycle pulse on each rising edge of the filtered level.
module fb_edge_filter
    import fb_speed_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYC    = DEF_FILT_CYC
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din_i,
    output logic rise_o
);

    localparam int STAB_W = clog2(FILT_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_bit;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // stab_q counts consecutive cycles in which the synchronised bit disagrees
    // with the filtered level; the level flips on the FILT_CYC-th such cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
        stab_d = '0;
        filt_d = filt_q;
        if (sync_bit != filt_q) begin
            if (stab_q == STAB_LAST) begin
                filt_d = sync_bit;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end
        rise_d = filt_d & ~filt_q;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_q <= '0;
            stab_q <= '0;
            filt_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            stab_q <= stab_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/fb_speed_meter.sv
// Multi-channel feedback pulse-rate meter: counts filtered rising edges per fixed window.
// Define FB_SPEED_AVG_EN to report a 4-window moving average instead of the raw count.
module fb_speed_meter
    import fb_speed_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int WIN_CYC     = DEF_WIN_CYC,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_CYC    = DEF_FILT_CYC
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [N_CH-1:0]        inp_fbp,
    output logic [N_CH*CNT_W-1:0]  edge_out,
    output logic [N_CH-1:0]        ovf,
    output logic                   valid,
    output logic [31:0]            win_cnt
);

    // Output protocol: valid is a single-cycle strobe with no back-pressure;
    // edge_out and ovf change only together with it and hold until the next strobe.

    localparam int WIN_W = clog2(WIN_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [N_CH-1:0]  rise;
    logic [WIN_W-1:0] win_q, win_d;
    logic             terminal;
    logic             valid_q;

    logic [CNT_W-1:0] live_q    [N_CH];
    logic [CNT_W-1:0] live_d    [N_CH];
    logic [CNT_W-1:0] cnt_nxt   [N_CH];
    logic [CNT_W-1:0] lat_q     [N_CH];
    logic [CNT_W-1:0] lat_d     [N_CH];
    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  sticky_q, sticky_d;
    logic [N_CH-1:0]  lat_ovf_q, lat_ovf_d;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        fb_edge_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC)
        ) u_filt (
            .clk    (clk),
            .n_rst  (n_rst),
            .din_i  (inp_fbp[k]),
            .rise_o (rise[k])
        );

        // Saturating increment; an edge at full scale is remembered as overflow.
        assign hit[k]     = rise[k] & (live_q[k] == CNT_MAX);
        assign cnt_nxt[k] = (rise[k] && !hit[k]) ? live_q[k] + CNT_W'(1) : live_q[k];
    end

    assign terminal = (win_q == WIN_LAST);

    always_comb begin
        win_d     = terminal ? '0 : win_q + WIN_W'(1);
        live_d    = live_q;
        lat_d     = lat_q;
        sticky_d  = sticky_q;
        lat_ovf_d = lat_ovf_q;
        for (int k = 0; k < N_CH; k++) begin
            if (terminal) begin
                // An edge landing on the terminal cycle belongs to the closing window.
                lat_d[k]     = cnt_nxt[k];
                lat_ovf_d[k] = sticky_q[k] | hit[k];
                live_d[k]    = '0;
                sticky_d[k]  = 1'b0;
            end else begin
                live_d[k]    = cnt_nxt[k];
                sticky_d[k]  = sticky_q[k] | hit[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            win_q     <= '0;
            sticky_q  <= '0;
            lat_ovf_q <= '0;
            valid_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                live_q[k] <= '0;
                lat_q[k]  <= '0;
            end
        end else begin
            win_q     <= win_d;
            live_q    <= live_d;
            lat_q     <= lat_d;
            sticky_q  <= sticky_d;
            lat_ovf_q <= lat_ovf_d;
            valid_q   <= terminal;
        end
    end

    assign win_cnt = 32'(win_q);

`ifdef FB_SPEED_AVG_EN
    localparam int SUM_W = CNT_W + 2;

    // lat_q is the newest of the four history entries; hist_q[k][0..2] are the older three.
    logic [CNT_W-1:0] hist_q  [N_CH][3];
    logic [2:0]       hovf_q  [N_CH];
    logic [SUM_W-1:0] sum     [N_CH];
    logic [CNT_W-1:0] avg_q   [N_CH];
    logic [N_CH-1:0]  avg_ovf_q;
    logic             avg_valid_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_sum
        assign sum[k] = SUM_W'(lat_q[k]) + SUM_W'(hist_q[k][0])
                      + SUM_W'(hist_q[k][1]) + SUM_W'(hist_q[k][2]);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            avg_ovf_q   <= '0;
            avg_valid_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                for (int j = 0; j < 3; j++) begin
                    hist_q[k][j] <= '0;
                end
                hovf_q[k] <= '0;
                avg_q[k]  <= '0;
            end
        end else begin
            avg_valid_q <= valid_q;
            for (int k = 0; k < N_CH; k++) begin
                if (terminal) begin
                    hist_q[k][0] <= lat_q[k];
                    hist_q[k][1] <= hist_q[k][0];
                    hist_q[k][2] <= hist_q[k][1];
                    hovf_q[k]    <= {hovf_q[k][1:0], lat_ovf_q[k]};
                end
                if (valid_q) begin
                    avg_q[k]     <= sum[k][SUM_W-1:2];
                    avg_ovf_q[k] <= lat_ovf_q[k] | (|hovf_q[k]);
                end
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_out
        assign edge_out[k*CNT_W +: CNT_W] = avg_q[k];
    end
    assign ovf   = avg_ovf_q;
    assign valid = avg_valid_q;
`else
    for (genvar k = 0; k < N_CH; k++) begin : g_out
        assign edge_out[k*CNT_W +: CNT_W] = lat_q[k];
    end
    assign ovf   = lat_ovf_q;
    assign valid = valid_q;
`endif

endmodule
